// File: rtl/hc8_trace_uart_tx.sv
// HC8 debug trace transmitter: snapshots PC and stack levels A/B/C on a trigger
// and sends them as a 6-byte 8N1 UART frame (sync, pc_hi, pc_lo, A, B, C).
module hc8_trace_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        trig,
  input  logic        clr_ovr,
  input  logic [15:0] pc_in,
  input  logic [7:0]  stackA_in,
  input  logic [7:0]  stackB_in,
  input  logic [7:0]  stackC_in,
  output logic        txd,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int            BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit_idx, w_bit_nxt;
  logic [2:0]    r_byte_idx, w_byte_nxt;
  logic [39:0]   r_snap;
  logic          r_txd, w_txd_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_overrun;
  logic          w_accept;
  logic          w_baud_wrap;
  logic [7:0]    w_cur_byte;

  assign w_accept    = trig && !r_busy;
  assign w_baud_wrap = (r_baud == BAUD_LAST);

  // State register; txd and busy are registered so the line never glitches.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order.
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_state_nxt = S_START;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_byte_nxt  = '0;
      end
    end else begin
      w_baud_nxt = w_baud_wrap ? '0 : r_baud + 1'b1;
      if (w_baud_wrap) begin
        case (r_state)
          S_START: w_state_nxt = S_DATA;
          S_DATA: begin
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = S_STOP;
              w_bit_nxt   = '0;
            end else begin
              w_bit_nxt = r_bit_idx + 3'd1;
            end
          end
          S_STOP: begin
            if (r_byte_idx < 3'd5) begin
              w_state_nxt = S_START;
              w_byte_nxt  = r_byte_idx + 3'd1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (r_byte_idx)
      3'd0:    w_cur_byte = SYNC_BYTE;
      3'd1:    w_cur_byte = r_snap[39:32];
      3'd2:    w_cur_byte = r_snap[31:24];
      3'd3:    w_cur_byte = r_snap[23:16];
      3'd4:    w_cur_byte = r_snap[15:8];
      default: w_cur_byte = r_snap[7:0];
    endcase
  end

  // Outputs are decoded from the upcoming state and then registered.
  always_comb begin
    w_txd_nxt  = 1'b1;
    w_busy_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:  w_busy_nxt = 1'b0;
      S_START: w_txd_nxt  = 1'b0;
      S_DATA:  w_txd_nxt  = w_cur_byte[w_bit_nxt];
      default: w_txd_nxt  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      // NOTE: the snapshot is cleared on reset so no stale core state survives.
      r_snap    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept)
        r_snap <= {pc_in, stackA_in, stackB_in, stackC_in};
      if (trig && r_busy)
        r_overrun <= 1'b1;
      else if (clr_ovr)
        r_overrun <= 1'b0;
    end
  end

  assign txd     = r_txd;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule
